// File: rtl/ac_seq.sv
// ---------------------------------------------------------------------------
// ac_seq -- control sequencer for the 8-bit accumulator datapath.
//
// Fetches 8-bit instructions from a 32-word synchronous memory (1-cycle read
// latency), decodes them and drives the accumulator strobes (wac/rac), the
// ALU operation select and the memory strobes. The sequencer is the only
// master of wac and rac.
//
// Instruction word: ir[7:5] = opcode, ir[4:0] = operand address.
//   000 NOP  001 LDA  010 STA  011 ADD  100 SUB  101 JMP  110 JZ  111 HLT
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   level-sampled in IDLE to begin execution
//   mem_rdata  in 8 memory read data, valid the cycle after mem_re
//   ac_zero    in   accumulator holds 0x00
//   mem_addr   out5 memory address
//   mem_re     out  memory read strobe
//   mem_we     out  memory write strobe (write data is the accumulator)
//   wac        out  accumulator write (captures ALU result)
//   rac        out  accumulator read onto the memory write bus
//   alu_op     out2 00 pass mem_rdata, 01 add, 10 sub, 11 reserved
//   pc         out5 program counter
//   busy       out  high in every state except IDLE and HALT
//   halted     out  high in HALT
//
// Configuration macro
//   AC_SEQ_STEP_EN  defined: single-step mode, every retired instruction
//                   returns to IDLE and the next start runs one more.
//                   undefined: free-run from start until HLT.
//
// All outputs are registered. They are computed from the next-state values
// so that, cycle for cycle, they equal a Moore decode of the registered
// state, ir and pc.
// ---------------------------------------------------------------------------
module ac_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    input  logic       ac_zero,
    output logic [4:0] mem_addr,
    output logic       mem_re,
    output logic       mem_we,
    output logic       wac,
    output logic       rac,
    output logic [1:0] alu_op,
    output logic [4:0] pc,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_STA = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_JZ  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Where an instruction goes once it has finished executing.
`ifdef AC_SEQ_STEP_EN
    localparam state_t ST_RETIRE = ST_IDLE;
`else
    localparam state_t ST_RETIRE = ST_FETCH;
`endif

    // Complete set of registered outputs (pc is carried separately).
    typedef struct packed {
        logic [4:0] addr;
        logic       re;
        logic       we;
        logic       wac;
        logic       rac;
        logic [1:0] alu;
        logic       busy;
        logic       halted;
    } strb_t;

    localparam strb_t STRB_RST = '{
        addr:   5'd0,
        re:     1'b0,
        we:     1'b0,
        wac:    1'b0,
        rac:    1'b0,
        alu:    2'b00,
        busy:   1'b0,
        halted: 1'b0
    };

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] pc_r;
    logic [4:0] pc_nxt_s;
    logic [7:0] ir_r;
    logic [7:0] ir_nxt_s;
    strb_t      strb_r;
    strb_t      strb_nxt_s;

    // Opcodes that read their operand from memory and write back via the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_LDA:  r = 1'b1;
            OP_ADD:  r = 1'b1;
            OP_SUB:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ALU select used during write-back.
    function automatic logic [1:0] alu_sel(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

    // Moore output decode of a (state, ir, pc) triple.
    function automatic strb_t decode_strobes(input state_t     st,
                                             input logic [7:0] ir_v,
                                             input logic [4:0] pc_v);
        strb_t o;
        o        = STRB_RST;
        o.addr   = pc_v;
        case (st)
            ST_FETCH: begin
                o.re   = 1'b1;
                o.busy = 1'b1;
            end
            ST_DECODE: begin
                o.busy = 1'b1;
            end
            ST_EXEC: begin
                o.busy = 1'b1;
                if (is_alu_op(ir_v[7:5])) begin
                    o.re   = 1'b1;
                    o.addr = ir_v[4:0];
                end else if (ir_v[7:5] == OP_STA) begin
                    o.rac  = 1'b1;
                    o.we   = 1'b1;
                    o.addr = ir_v[4:0];
                end else begin
                    o.addr = pc_v;
                end
            end
            ST_WB: begin
                o.busy = 1'b1;
                o.wac  = 1'b1;
                o.alu  = alu_sel(ir_v[7:5]);
            end
            ST_HALT: begin
                o.halted = 1'b1;
            end
            default: begin
                o.addr = pc_v;
            end
        endcase
        return o;
    endfunction

    // Next state, program counter and instruction register.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                // Read data for the FETCH issued last cycle is valid now.
                ir_nxt_s    = mem_rdata;
                pc_nxt_s    = pc_r + 5'd1;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_r[7:5])
                    OP_LDA, OP_ADD, OP_SUB: begin
                        state_nxt_s = ST_WB;
                    end
                    OP_STA: begin
                        state_nxt_s = ST_RETIRE;
                    end
                    OP_JMP: begin
                        pc_nxt_s    = ir_r[4:0];
                        state_nxt_s = ST_RETIRE;
                    end
                    OP_JZ: begin
                        if (ac_zero) begin
                            pc_nxt_s = ir_r[4:0];
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                        state_nxt_s = ST_RETIRE;
                    end
                    OP_HLT: begin
                        state_nxt_s = ST_HALT;
                    end
                    OP_NOP: begin
                        state_nxt_s = ST_RETIRE;
                    end
                    default: begin
                        state_nxt_s = ST_RETIRE;
                    end
                endcase
            end
            ST_WB: begin
                state_nxt_s = ST_RETIRE;
            end
            ST_HALT: begin
                // Only reset leaves HALT.
                state_nxt_s = ST_HALT;
            end
            default: begin
                // Unreachable encodings recover to a safe idle state.
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = 5'd0;
                ir_nxt_s    = 8'h00;
            end
        endcase
    end

    // Outputs for the cycle that follows the next edge.
    always_comb begin
        strb_nxt_s = decode_strobes(state_nxt_s, ir_nxt_s, pc_nxt_s);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= 5'd0;
            ir_r    <= 8'h00;
            strb_r  <= STRB_RST;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
            strb_r  <= strb_nxt_s;
        end
    end

    assign mem_addr = strb_r.addr;
    assign mem_re   = strb_r.re;
    assign mem_we   = strb_r.we;
    assign wac      = strb_r.wac;
    assign rac      = strb_r.rac;
    assign alu_op   = strb_r.alu;
    assign busy     = strb_r.busy;
    assign halted   = strb_r.halted;
    assign pc       = pc_r;

endmodule
